// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite subordinate with three read/write control registers and one read-only status word.
// The write and read channels each run an independent single-outstanding handshake FSM.
module axi_lite_slave_regs #(
    parameter int AXI_DATAW      = 32,
    parameter int AXI_ADDRW      = 4,
    parameter int AXI_DATAW_BYTE = AXI_DATAW >> 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDRW-1:0]      awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [AXI_DATAW-1:0]      wdata,
    input  logic [AXI_DATAW_BYTE-1:0] wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [AXI_ADDRW-1:0]      araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [AXI_DATAW-1:0]      rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [AXI_DATAW-1:0]      reg0_out,
    output logic [AXI_DATAW-1:0]      reg1_out,
    output logic [AXI_DATAW-1:0]      reg2_out,
    input  logic [AXI_DATAW-1:0]      status_in,
    output logic [2:0]                wr_pulse
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    wr_state_t                 wr_state, wr_state_n;
    rd_state_t                 rd_state, rd_state_n;
    logic [AXI_DATAW-1:0]      ctrl [3];

    logic                      aw_held, aw_held_n;
    logic [1:0]                aw_idx, aw_idx_n;
    logic                      w_held, w_held_n;
    logic [AXI_DATAW-1:0]      w_data, w_data_n;
    logic [AXI_DATAW_BYTE-1:0] w_strb, w_strb_n;
    logic                      awready_n, wready_n, bvalid_n;
    logic [1:0]                bresp_n;
    logic [2:0]                wr_pulse_n;
    logic                      commit;
    logic [1:0]                commit_idx;
    logic [AXI_DATAW-1:0]      commit_data;
    logic [AXI_DATAW_BYTE-1:0] commit_strb;
    logic                      aw_hs, w_hs, ar_hs;

    logic                      arready_n, rvalid_n;
    logic [AXI_DATAW-1:0]      rdata_n;

    logic                      unused_ok;
    assign unused_ok = ^{awprot, arprot, awaddr, araddr};

    assign reg0_out = ctrl[0];
    assign reg1_out = ctrl[1];
    assign reg2_out = ctrl[2];
    assign rresp    = RESP_OKAY;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;

    // Commit uses the freshly presented beat when it arrives on the completing edge.
    always_comb begin
        wr_state_n  = wr_state;
        aw_held_n   = aw_held;
        aw_idx_n    = aw_idx;
        w_held_n    = w_held;
        w_data_n    = w_data;
        w_strb_n    = w_strb;
        awready_n   = awready;
        wready_n    = wready;
        bvalid_n    = bvalid;
        bresp_n     = bresp;
        wr_pulse_n  = '0;
        commit      = 1'b0;
        commit_idx  = aw_idx;
        commit_data = w_data;
        commit_strb = w_strb;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_held_n  = 1'b1;
                    aw_idx_n   = awaddr[3:2];
                    commit_idx = awaddr[3:2];
                end
                if (w_hs) begin
                    w_held_n    = 1'b1;
                    w_data_n    = wdata;
                    w_strb_n    = wstrb;
                    commit_data = wdata;
                    commit_strb = wstrb;
                end
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    commit     = 1'b1;
                    wr_state_n = WR_RESP;
                    awready_n  = 1'b0;
                    wready_n   = 1'b0;
                    bvalid_n   = 1'b1;
                    bresp_n    = (commit_idx == 2'd3) ? RESP_SLVERR : RESP_OKAY;
                    wr_pulse_n = (commit_idx == 2'd3) ? 3'b000 : (3'b001 << commit_idx);
                end else begin
                    awready_n = !(aw_held || aw_hs);
                    wready_n  = !(w_held || w_hs);
                end
            end
            WR_RESP: begin
                if (bready) begin
                    wr_state_n = WR_IDLE;
                    bvalid_n   = 1'b0;
                    awready_n  = 1'b1;
                    wready_n   = 1'b1;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                end
            end
            default: wr_state_n = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state <= WR_IDLE;
            aw_held  <= 1'b0;
            aw_idx   <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= '0;
            wr_pulse <= '0;
            for (int unsigned r = 0; r < 3; r++) ctrl[r] <= '0;
        end else begin
            wr_state <= wr_state_n;
            aw_held  <= aw_held_n;
            aw_idx   <= aw_idx_n;
            w_held   <= w_held_n;
            w_data   <= w_data_n;
            w_strb   <= w_strb_n;
            awready  <= awready_n;
            wready   <= wready_n;
            bvalid   <= bvalid_n;
            bresp    <= bresp_n;
            wr_pulse <= wr_pulse_n;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned b = 0; b < AXI_DATAW_BYTE; b++) begin
                    if (commit && commit_idx == 2'(r) && commit_strb[b])
                        ctrl[r][8*b +: 8] <= commit_data[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured from the pre-edge register contents.
    always_comb begin
        rd_state_n = rd_state;
        arready_n  = arready;
        rvalid_n   = rvalid;
        rdata_n    = rdata;
        case (rd_state)
            RD_IDLE: begin
                arready_n = 1'b1;
                if (ar_hs) begin
                    rd_state_n = RD_RESP;
                    arready_n  = 1'b0;
                    rvalid_n   = 1'b1;
                    case (araddr[3:2])
                        2'd0:    rdata_n = ctrl[0];
                        2'd1:    rdata_n = ctrl[1];
                        2'd2:    rdata_n = ctrl[2];
                        default: rdata_n = status_in;
                    endcase
                end
            end
            RD_RESP: begin
                if (rready) begin
                    rd_state_n = RD_IDLE;
                    rvalid_n   = 1'b0;
                    arready_n  = 1'b1;
                end
            end
            default: rd_state_n = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= RD_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
        end else begin
            rd_state <= rd_state_n;
            arready  <= arready_n;
            rvalid   <= rvalid_n;
            rdata    <= rdata_n;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed and randomized checks of axi_lite_slave_regs against a word-level register model.
module tb_axi_lite_slave_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata, status_in;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, reg0_out, reg1_out, reg2_out;
    logic [2:0]  wr_pulse;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [31:0] model [3];

    axi_lite_slave_regs #(.AXI_DATAW(32), .AXI_ADDRW(4)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
        .status_in(status_in), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_reg0"}, reg0_out, model[0]);
        check({tag, "_reg1"}, reg1_out, model[1]);
        check({tag, "_reg2"}, reg2_out, model[2]);
    endtask

    function automatic void model_write(input logic [3:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [31:0] mask;
        int          idx;
        idx  = int'(addr) / 4;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (idx < 3) model[idx] = (model[idx] & ~mask) | (data & mask);
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        int idx;
        idx = int'(addr) / 4;
        return (idx < 3) ? model[idx] : status_in;
    endfunction

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int c = 0, idx;
        idx    = int'(addr) / 4;
        bready = 1'b1;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        while (!(aw_done && w_done) && c < 50) begin
            awvalid = (c >= aw_dly) && !aw_done;
            wvalid  = (c >= w_dly) && !w_done;
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            check("no_early_bvalid", {31'b0, bvalid}, 32'd0);
            tick();
            aw_done |= aw_hs;
            w_done  |= w_hs;
            if (w_done && !aw_done) check("wready_low_after_w", {31'b0, wready}, 32'd0);
            if (aw_done && !w_done) check("awready_low_after_aw", {31'b0, awready}, 32'd0);
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("write_handshake_timeout", 32'd0, 32'd1);
        model_write(addr, data, strb);
        check("bvalid_after_commit", {31'b0, bvalid}, 32'd1);
        check("bresp", {30'b0, bresp}, (idx == 3) ? 32'd2 : 32'd0);
        check("wr_pulse", {29'b0, wr_pulse}, (idx == 3) ? 32'd0 : (32'd1 << idx));
        check("ready_low_in_resp", {30'b0, awready, wready}, 32'd0);
        check_regs("after_write");
        tick();
        check("bvalid_cleared", {31'b0, bvalid}, 32'd0);
        check("wr_pulse_one_cycle", {29'b0, wr_pulse}, 32'd0);
        check("ready_restored", {30'b0, awready, wready}, 32'd3);
    endtask

    task automatic do_read(input logic [3:0] addr, input int hold);
        logic [31:0] exp;
        int c = 0;
        bit hs = 0;
        araddr = addr;
        rready = 1'b0;
        while (!hs && c < 50) begin
            arvalid = 1'b1;
            hs      = arready;
            exp     = model_read(addr);
            tick();
            c++;
        end
        arvalid = 1'b0;
        if (!hs) check("read_handshake_timeout", 32'd0, 32'd1);
        for (int k = 0; k <= hold; k++) begin
            check("rvalid_held", {31'b0, rvalid}, 32'd1);
            check("rdata", rdata, exp);
            check("rresp", {30'b0, rresp}, 32'd0);
            check("arready_low", {31'b0, arready}, 32'd0);
            if (k == hold) rready = 1'b1;
            tick();
        end
        rready = 1'b0;
        check("rvalid_cleared", {31'b0, rvalid}, 32'd0);
        check("arready_restored", {31'b0, arready}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        {awaddr, araddr, awprot, arprot} = '0;
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        {wdata, wstrb} = '0;
        status_in = 32'h0;
        for (int r = 0; r < 3; r++) model[r] = '0;

        tick();
        tick();
        check("rst_readies", {29'b0, awready, wready, arready}, 32'd0);
        check("rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
        check_regs("rst");
        #2 rst = 1'b1;
        tick();
        check("readies_after_release", {29'b0, awready, wready, arready}, 32'd7);

        do_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0);
        do_write(4'h0, 32'h11223344, 4'b0101, 3, 0);
        check("partial_strobe_reg0", reg0_out, 32'h00220044);
        do_write(4'hC, 32'h55555555, 4'hF, 0, 0);
        do_write(4'h1, 32'hFFFFFFFF, 4'h0, 0, 2);
        status_in = 32'hCAFE0001;
        do_read(4'hC, 0);
        do_read(4'h8, 5);
        do_write(4'hA, 32'h12345678, 4'hF, 1, 0);

        // Write commit to reg2 and read of reg2 on the same edge.
        check("idle_readies", {29'b0, awready, wready, arready}, 32'd7);
        awaddr = 4'h8; wdata = 32'hAAAA5555; wstrb = 4'hF; araddr = 4'h8;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_edge_read_old", rdata, model[2]);
        model_write(4'h8, 32'hAAAA5555, 4'hF);
        check("same_edge_reg2_new", reg2_out, 32'hAAAA5555);
        bready = 1'b1; rready = 1'b1;
        tick();
        rready = 1'b0;
        do_read(4'h8, 1);

        for (int n = 0; n < 25; n++) begin
            status_in = $urandom;
            do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            do_read(4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        // Reset with both response channels stalled.
        awaddr = 4'h0; wdata = 32'h01020304; wstrb = 4'hF; araddr = 4'h4;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("stalled_valids", {30'b0, bvalid, rvalid}, 32'd3);
        #2 rst = 1'b0;
        #1;
        for (int r = 0; r < 3; r++) model[r] = '0;
        check("async_rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
        check("async_rst_readies", {29'b0, awready, wready, arready}, 32'd0);
        check("async_rst_misc", {27'b0, wr_pulse, bresp}, 32'd0);
        check("async_rst_rdata", rdata, 32'd0);
        check_regs("async_rst");
        tick();
        check("rst_hold_readies", {29'b0, awready, wready, arready}, 32'd0);
        #2 rst = 1'b1;
        tick();
        check("readies_after_rerelease", {29'b0, awready, wready, arready}, 32'd7);
        check("no_resp_after_rst", {30'b0, bvalid, rvalid}, 32'd0);
        do_write(4'h4, 32'h0BADF00D, 4'b1100, 0, 1);
        do_read(4'h4, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite subordinate exposing four 32-bit registers to a bus master (the core-side AXI master issuing single-beat reads and writes). Registers 0–2 are read/write control registers driven out to fabric logic; register 3 is a read-only status word sampled from fabric. Read and write channels run independently, one outstanding transaction each.

## Interface
- AXI_DATAW, 32, data width; only 32 is supported
- AXI_ADDRW, 4, address width; word index is addr[3:2]; bits [1:0] and any bits above 3 are ignored (aliasing)
- AXI_DATAW_BYTE, AXI_DATAW>>3, strobe width
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- awaddr  in  AXI_ADDRW  write address
- awprot  in  3  ignored
- awvalid  in  1 / awready  out  1
- wdata  in  AXI_DATAW / wstrb  in  AXI_DATAW_BYTE / wvalid  in  1 / wready  out  1
- bresp  out  2 / bvalid  out  1 / bready  in  1
- araddr  in  AXI_ADDRW / arprot  in  3 (ignored) / arvalid  in  1 / arready  out  1
- rdata  out  AXI_DATAW / rresp  out  2 / rvalid  out  1 / rready  in  1
- reg0_out, reg1_out, reg2_out  out  AXI_DATAW  current register contents
- status_in  in  AXI_DATAW  value returned for register 3
- wr_pulse  out  3  one-cycle strobe, bit i = register i was written

## Operation
- Write path: AW and W accepted independently, in either order or same cycle; each captured in its own holding register, and its ready drops after capture.
- Commit when both held: registers with index 0–2 updated per byte lane where wstrb bit set; bresp=2'b00; wr_pulse[idx]=1. Index 3: no update, no pulse, bresp=2'b10 (SLVERR). wstrb=0 to index 0–2: no data change, bresp=00, pulse still asserted.
- bvalid rises with commit, held with bresp stable until bready. After B handshake, awready and wready return to 1 and holding registers clear.
- Read path: AR handshake captures index; rdata = reg0/1/2 or status_in sampled at the AR handshake edge; rresp always 2'b00. rvalid held with rdata stable until rready; arready low meanwhile, returns to 1 after R handshake.
- Read of a register being committed on the same edge returns the old value.
- Reset (any time, including mid-transaction): outstanding transactions dropped; all registers 0; bvalid, rvalid, wr_pulse, bresp, rresp, rdata = 0; awready, wready, arready = 0 while rst low.

## Timing
- Ready outputs registered; first cycle after rst deasserts: awready=wready=arready=1.
- AW and W handshake in cycle T (or later of the two at T): commit edge ends T; bvalid=1, new reg value and wr_pulse visible in T+1. wr_pulse is 1 for exactly that cycle.
- bready=1 in T+1: handshake at T+1; awready/wready=1 in T+2. Peak write rate one per 2 cycles.
- AR handshake at T: rvalid=1 with data in T+1; rready=1 in T+1 → arready=1 in T+2.
- awready low from cycle after AW capture until cycle after B handshake; wready likewise.
- Back-pressure: bvalid/rvalid may be held arbitrarily long; no new transaction accepted on that channel until released.

## Test plan
- Reset, then write 0xDEADBEEF to addr 0x4, wstrb=4'hF, bready=1 -> bvalid one cycle after handshake, bresp=00, reg1_out=0xDEADBEEF, wr_pulse=3'b010 for one cycle.
- W presented 3 cycles before AW (addr 0x0, data 0x11223344, wstrb=4'b0101) -> no commit until AW; then reg0_out=0x00220044 from reset 0, bresp=00.
- Write addr 0xC -> bresp=10, status unchanged, wr_pulse=0; read addr 0xC with status_in=0xCAFE0001 -> rdata=0xCAFE0001, rresp=00.
- Read addr 0x8 with rready held low 5 cycles -> rvalid and rdata stable throughout, arready=0 until cycle after handshake.
- Same-cycle write commit to reg2 (0xAAAA5555 over 0x12345678) and AR to 0x8 -> rdata=0x12345678; subsequent read returns 0xAAAA5555.
- Assert rst while bvalid=1 and rvalid=1 -> all outputs 0 immediately, reg0–2 = 0; readies return 1 first cycle after release.
